// File: rtl/physics_pkg.sv
// Shared types and constants for the physics state read-back path.
// Builds with or without SNAPSHOT_CHECKSUM_EN; nothing here depends on it.
package physics_pkg;

  localparam logic [15:0] SNAP_MAGIC = 16'hA5A5;

  typedef enum logic [1:0] {SNAP_IDLE, SNAP_HEADER, SNAP_STREAM, SNAP_CKSUM} snap_state_t;

  typedef logic [31:0] fx_word_t;

  function automatic fx_word_t snap_header(input logic [7:0] sprites, input logic [7:0] dims);
    return {SNAP_MAGIC, sprites, dims};
  endfunction

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Pulse is one cycle wide and rises 3 cycles after the raw input rises.
module button_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = btn_in;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/state_snapshot_reader.sv
// Freezes sprite locations/velocities on a capture press and streams them as a framed word sequence.
// Define SNAPSHOT_CHECKSUM_EN to append an XOR checksum word that carries out_last.
module state_snapshot_reader
  import physics_pkg::*;
#(
  parameter int SPRITES    = 4,
  parameter int DIMENSIONS = 2,
  parameter int WIDTH      = 32
) (
  input  logic                                clock_162,
  input  logic                                rst,
  input  logic                                capture,
  input  logic [SPRITES*DIMENSIONS*WIDTH-1:0] locations,
  input  logic [SPRITES*DIMENSIONS*WIDTH-1:0] velos,
  output logic [WIDTH-1:0]                    out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                dropped
);

  localparam int NWORDS = 2 * SPRITES * DIMENSIONS;
  localparam int IDX_W  = $clog2(NWORDS + 1);
  localparam fx_word_t HEADER = snap_header(8'(SPRITES), 8'(DIMENSIONS));

  if (WIDTH != 32) begin : g_width_chk
    $fatal(1, "state_snapshot_reader: WIDTH must be 32");
  end

  logic cap_pulse;

  button_edge_sync u_capture_sync (
    .clk    (clock_162),
    .rst    (rst),
    .btn_in (capture),
    .pulse  (cap_pulse)
  );

  snap_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic dropped_q, dropped_d;
  fx_word_t snap_q [NWORDS];
  fx_word_t snap_d [NWORDS];
  fx_word_t cur_word;
  logic accept;
  logic last_data;

  assign accept    = (state_q != SNAP_IDLE) && out_ready;
  assign last_data = (idx_q == IDX_W'(NWORDS - 1));

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx_q == IDX_W'(k)) cur_word = snap_q[k];
    end
  end

  always_ff @(posedge clock_162) begin
    if (rst) begin
      state_q   <= SNAP_IDLE;
      idx_q     <= '0;
      dropped_q <= 1'b0;
      snap_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
      snap_q    <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SNAP_IDLE:   if (cap_pulse) state_d = SNAP_HEADER;
      SNAP_HEADER: if (accept) state_d = SNAP_STREAM;
`ifdef SNAPSHOT_CHECKSUM_EN
      SNAP_STREAM: if (accept && last_data) state_d = SNAP_CKSUM;
      SNAP_CKSUM:  if (accept) state_d = SNAP_IDLE;
`else
      SNAP_STREAM: if (accept && last_data) state_d = SNAP_IDLE;
`endif
      default:     state_d = SNAP_IDLE;
    endcase
  end

  // Snapshot is laid out in stream order so the word index selects it directly.
  always_comb begin
    snap_d    = snap_q;
    idx_d     = idx_q;
    dropped_d = dropped_q;
    if (state_q == SNAP_IDLE) begin
      if (cap_pulse) begin
        dropped_d = 1'b0;
        idx_d     = '0;
        for (int s = 0; s < SPRITES; s++) begin
          for (int d = 0; d < DIMENSIONS; d++) begin
            snap_d[s*2*DIMENSIONS + d]              = locations[(s*DIMENSIONS + d)*WIDTH +: WIDTH];
            snap_d[s*2*DIMENSIONS + DIMENSIONS + d] = velos[(s*DIMENSIONS + d)*WIDTH +: WIDTH];
          end
        end
      end
    end else if (cap_pulse) begin
      dropped_d = 1'b1;
    end
    if (state_q == SNAP_STREAM && accept) begin
      idx_d = last_data ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef SNAPSHOT_CHECKSUM_EN
  fx_word_t cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == SNAP_IDLE && cap_pulse) cksum_d = HEADER;
    else if (state_q == SNAP_STREAM && accept) cksum_d = cksum_q ^ cur_word;
  end

  always_ff @(posedge clock_162) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end
`endif

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      SNAP_HEADER: out_data = HEADER;
`ifdef SNAPSHOT_CHECKSUM_EN
      SNAP_STREAM: out_data = cur_word;
      SNAP_CKSUM: begin
        out_data = cksum_q;
        out_last = 1'b1;
      end
`else
      SNAP_STREAM: begin
        out_data = cur_word;
        out_last = last_data;
      end
`endif
      default: ;
    endcase
  end

  assign out_valid = (state_q != SNAP_IDLE);
  assign busy      = (state_q != SNAP_IDLE);
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_state_snapshot_reader.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops and compares on each accept.
module tb_state_snapshot_reader;

  localparam int S = 4;
  localparam int D = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, capture, out_ready;
  logic [S*D*W-1:0] locations, velos;
  logic [W-1:0] out_data;
  logic out_valid, out_last, busy, dropped;

  always #3 clk = ~clk;

  state_snapshot_reader #(.SPRITES(S), .DIMENSIONS(D), .WIDTH(W)) dut (
    .clock_162 (clk),
    .rst       (rst),
    .capture   (capture),
    .locations (locations),
    .velos     (velos),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .dropped   (dropped)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  logic [31:0] loc_m [S][D];
  logic [31:0] vel_m [S][D];
  exp_t exp_q [$];
  int checks = 0;
  int passes = 0;
  int accepted = 0;
  int frame_len = 0;
  bit rand_ready = 1'b0;
  logic [31:0] last_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_inputs;
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin
        locations[(s*D + d)*W +: W] = loc_m[s][d];
        velos[(s*D + d)*W +: W]     = vel_m[s][d];
      end
    end
  endtask

  task automatic randomize_state;
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin
        loc_m[s][d] = $urandom;
        vel_m[s][d] = $urandom;
      end
    end
    apply_inputs();
  endtask

  // Expected frame straight from the documented word order.
  task automatic push_frame;
    logic [31:0] w [$];
    logic [31:0] x;
    exp_t e;
    w.push_back(32'hA5A5_0000 + 32'(S * 256 + D));
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) w.push_back(loc_m[s][d]);
      for (int d = 0; d < D; d++) w.push_back(vel_m[s][d]);
    end
`ifdef SNAPSHOT_CHECKSUM_EN
    x = '0;
    foreach (w[i]) x = x ^ w[i];
    w.push_back(x);
`endif
    frame_len = w.size();
    foreach (w[i]) begin
      e.dat  = w[i];
      e.last = (i == w.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic raw_press;
    capture = 1'b1;
    tick(4);
    capture = 1'b0;
  endtask

  task automatic wait_accepted(input int target, input string name);
    int n = 0;
    while (accepted < target && n < 1000) begin
      tick(1);
      n++;
    end
    if (accepted < target) begin
      checks++;
      $display("FAIL %s: timed out at %0d words, wanted %0d", name, accepted, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 1000) begin
      tick(1);
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s: frame did not finish, busy=%0b pending=%0d", name, busy, exp_q.size());
    end
  endtask

  task automatic run_frame(input string name);
    int start;
    start = accepted;
    push_frame();
    raw_press();
    wait_idle(name);
    check({name, "_len"}, 32'(accepted - start), 32'(frame_len));
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  logic prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;
  logic prev_last = 1'b0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, prev_dat);
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h with nothing outstanding", out_data);
        end else begin
          e_mon = exp_q.pop_front();
          check("word", out_data, e_mon.dat);
          check("last", 32'(out_last), 32'(e_mon.last));
          last_dat = out_data;
          accepted++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst = 1'b1;
    capture = 1'b0;
    out_ready = 1'b0;
    locations = '0;
    velos = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", out_data, 32'd0);

    // Preset-style frame with fixed leading sprite, plus capture latency.
    randomize_state();
    loc_m[0][0] = 32'h0100_0000;
    loc_m[0][1] = 32'h0100_0000;
    vel_m[0][0] = 32'h0000_0000;
    vel_m[0][1] = 32'h0010_0000;
    apply_inputs();
    out_ready = 1'b1;
    start = accepted;
    push_frame();
    capture = 1'b1;
    tick(3);
    check("latency_early", 32'(out_valid), 32'd0);
    tick(1);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_busy", 32'(busy), 32'd1);
    capture = 1'b0;
    wait_idle("preset");
    check("preset_len", 32'(accepted - start), 32'(frame_len));
    check("preset_dropped", 32'(dropped), 32'd0);

    // Random state under random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      randomize_state();
      run_frame("bp");
    end

    // Inputs change mid-frame; stream keeps captured values.
    randomize_state();
    start = accepted;
    push_frame();
    raw_press();
    wait_accepted(start + 4, "midchg_wait");
    loc_m[0][0] = 32'hDEAD_BEEF;
    apply_inputs();
    wait_idle("midchg");
    check("midchg_len", 32'(accepted - start), 32'(frame_len));

    // Second press during a frame is dropped and does not disturb it.
    rand_ready = 1'b0;
    out_ready = 1'b1;
    randomize_state();
    start = accepted;
    push_frame();
    raw_press();
    wait_accepted(start + 5, "drop_wait");
    raw_press();
    tick(2);
    check("drop_busy", 32'(busy), 32'd1);
    check("drop_set", 32'(dropped), 32'd1);
    wait_idle("drop");
    check("drop_len", 32'(accepted - start), 32'(frame_len));
    check("drop_sticky", 32'(dropped), 32'd1);
    randomize_state();
    push_frame();
    capture = 1'b1;
    tick(4);
    capture = 1'b0;
    check("drop_clear", 32'(dropped), 32'd0);
    wait_idle("after_drop");

    // Reset mid-frame aborts, then a fresh capture starts with the header.
    randomize_state();
    start = accepted;
    push_frame();
    raw_press();
    wait_accepted(start + 8, "rst_wait");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_last", 32'(out_last), 32'd0);
    check("abort_data", out_data, 32'd0);
    tick(2);
    randomize_state();
    run_frame("post_rst");

`ifdef SNAPSHOT_CHECKSUM_EN
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin
        loc_m[s][d] = '0;
        vel_m[s][d] = '0;
      end
    end
    apply_inputs();
    run_frame("cksum_zero");
    check("cksum_zero_word", last_dat, 32'hA5A5_0402);
`endif

    tick(5);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
